// File: rtl/recip_nr_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// recip_nr_pipe
// Fixed-point reciprocal x_inv = 1/x_in, both in Q(W-F).F.
// The operand magnitude is normalised into [0.5,1), seeded from a small table
// and refined by ITERS Newton-Raphson steps y <- y*(2 - x*y). The result is
// then denormalised, saturated and sign-restored.
// One operation is in flight at a time; the unit is sequenced by a small FSM.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand valid
//   in_ready   out  unit idle and able to take an operand
//   x_in       in   operand, Q(W-F).F (two's complement when SIGNED_MODE=1)
//   flush      in   abort the operation in flight (ignored while idle)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   x_inv      out  reciprocal, Q(W-F).F
//   div_zero   out  operand was zero (qualified by out_valid)
//   ovf        out  result saturated (qualified by out_valid)
// -----------------------------------------------------------------------------
module recip_nr_pipe #(
   parameter int W           = 32,
   parameter int F           = 16,
   parameter int ITERS       = 3,
   parameter int LUT_BITS    = 4,
   parameter int SIGNED_MODE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x_in,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x_inv,
   output logic         div_zero,
   output logic         ovf
);

   localparam int PW    = $clog2(W);
   localparam int EW    = $clog2(W) + 2;
   localparam int IW    = 3;
   localparam int DEPTH = 2 ** LUT_BITS;

   // Largest representable result magnitude; negative saturation is -MAX_MAG.
   localparam logic [W-1:0] MAX_MAG = (SIGNED_MODE != 0) ? {1'b0, {(W-1){1'b1}}}
                                                           : {W{1'b1}};
   // Fraction bits of the normalised operand below its leading one (bit F-1).
   localparam logic [W-1:0] FRAC_MASK = {{(W-F+1){1'b0}}, {(F-1){1'b1}}};
   // The constant 2.0 in the QF domain used by the refinement step.
   localparam logic [2*W-1:0] TWO_Q = (2*W)'(1) << (F + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_NORM = 3'd1;
   localparam logic [2:0] S_SEED = 3'd2;
   localparam logic [2:0] S_ITA  = 3'd3;
   localparam logic [2:0] S_ITB  = 3'd4;
   localparam logic [2:0] S_DEN  = 3'd5;
   localparam logic [2:0] S_OUT  = 3'd6;

   // Seed for segment k: floor(2^F / m), m = midpoint of the k-th slice of [0.5,1).
   // m = (2^(L+1) + 2k + 1) / 2^(L+2), so the seed is 2^(F+L+2) / (2^(L+1)+2k+1).
   function automatic logic [W-1:0] seed_val(input int k);
      logic [W+LUT_BITS+3:0] num;
      logic [W+LUT_BITS+3:0] den;
      num = '0;
      num[F+LUT_BITS+2] = 1'b1;
      den = (W+LUT_BITS+4)'((2 ** (LUT_BITS + 1)) + (2 * k) + 1);
      return W'(num / den);
   endfunction

   logic [2:0]          r_state;
   logic [IW-1:0]       r_iter;
   logic                r_sign;
   logic [W-1:0]        r_absx;
   logic [W-1:0]        r_xn;
   logic signed [EW-1:0] r_exp;
   logic [W-1:0]        r_y;
   logic [W-1:0]        r_t;
   logic [W-1:0]        r_x_inv;
   logic                r_div_zero;
   logic                r_ovf;

   logic [W-1:0]        w_seed_tab [DEPTH];
   logic                w_neg_in;
   logic [W-1:0]        w_abs_in;
   logic [PW-1:0]       w_msb;
   logic signed [EW-1:0] w_exp;
   logic [W-1:0]        w_xn;
   logic [LUT_BITS-1:0] w_k;
   logic [2*W-1:0]      w_prod_t;
   logic [2*W-1:0]      w_prod_y;
   logic [2*W-1:0]      w_scaled;
   logic                w_sat;
   logic [W-1:0]        w_mag;
   logic [W-1:0]        w_res;

   // Seed table, fixed at elaboration.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_seed
         assign w_seed_tab[gi] = seed_val(gi);
      end
   endgenerate

   // Operand magnitude; -2^(W-1) negates to itself and is read as unsigned 2^(W-1).
   assign w_neg_in = (SIGNED_MODE != 0) && x_in[W-1];
   assign w_abs_in = w_neg_in ? (-x_in) : x_in;

   // Leading-one position of the magnitude (later iterations win = highest bit).
   always_comb begin
      w_msb = '0;
      for (int i = 0; i < W; i++) begin
         if (r_absx[i]) begin
            w_msb = PW'(i);
         end
      end
   end

   // Move the leading one to bit F-1 so x_n lies in [0.5,1); e records the shift.
   always_comb begin
      w_exp = $signed(EW'(w_msb)) - $signed(EW'(F - 1));
      if (!w_exp[EW-1]) begin
         w_xn = r_absx >> w_exp;
      end else begin
         w_xn = r_absx << (-w_exp);
      end
   end

   // Table index: the LUT_BITS bits just below the leading one, zero-filled when
   // fewer fraction bits exist.
   assign w_k = LUT_BITS'({(r_xn & FRAC_MASK), {LUT_BITS{1'b0}}} >> (F - 1));

   // Refinement products, both at double width before truncation.
   assign w_prod_t = (2*W)'(r_xn) * (2*W)'(r_y);
   assign w_prod_y = (2*W)'(r_y) * (TWO_Q - (2*W)'(r_t));

   // Undo the normalisation: 1/x = (1/x_n) * 2^-e. Left shifts stay exact at 2W bits.
   always_comb begin
      if (!r_exp[EW-1]) begin
         w_scaled = (2*W)'(r_y) >> r_exp;
      end else begin
         w_scaled = (2*W)'(r_y) << (-r_exp);
      end
   end

   assign w_sat = w_scaled > (2*W)'(MAX_MAG);
   assign w_mag = w_sat ? MAX_MAG : w_scaled[W-1:0];
   assign w_res = r_sign ? (-w_mag) : w_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_iter     <= '0;
         r_sign     <= 1'b0;
         r_absx     <= '0;
         r_xn       <= '0;
         r_exp      <= '0;
         r_y        <= '0;
         r_t        <= '0;
         r_x_inv    <= '0;
         r_div_zero <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (flush && (r_state != S_IDLE)) begin
         r_state    <= S_IDLE;
         r_x_inv    <= '0;
         r_div_zero <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign <= w_neg_in;
                  r_absx <= w_abs_in;
                  if (x_in == '0) begin
                     // Zero skips the datapath and reports saturated positive max.
                     r_x_inv    <= MAX_MAG;
                     r_div_zero <= 1'b1;
                     r_ovf      <= 1'b0;
                     r_state    <= S_OUT;
                  end else begin
                     r_state <= S_NORM;
                  end
               end
            end
            S_NORM: begin
               r_xn    <= w_xn;
               r_exp   <= w_exp;
               r_state <= S_SEED;
            end
            S_SEED: begin
               r_y     <= w_seed_tab[w_k];
               r_iter  <= '0;
               r_state <= S_ITA;
            end
            S_ITA: begin
               r_t     <= W'(w_prod_t >> F);
               r_state <= S_ITB;
            end
            S_ITB: begin
               r_y <= W'(w_prod_y >> F);
               if (r_iter == IW'(ITERS - 1)) begin
                  r_state <= S_DEN;
               end else begin
                  r_iter  <= r_iter + IW'(1);
                  r_state <= S_ITA;
               end
            end
            S_DEN: begin
               r_x_inv    <= w_res;
               r_ovf      <= w_sat;
               r_div_zero <= 1'b0;
               r_state    <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_x_inv    <= '0;
                  r_div_zero <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign x_inv     = r_x_inv;
   assign div_zero  = r_div_zero;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_recip_nr_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_recip_nr_pipe
// Drives a signed and an unsigned instance of recip_nr_pipe in lockstep with
// the same operands and checks both against an arithmetic reciprocal model.
// -----------------------------------------------------------------------------
module tb_recip_nr_pipe;

   localparam int W     = 32;
   localparam int F     = 16;
   localparam int ITERS = 3;
   localparam int LAT   = 3 + 2 * ITERS;
   localparam int N_RND = 2000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  x_in;
   logic          flush;
   logic          out_ready;

   logic          s_in_ready, s_out_valid, s_div_zero, s_ovf;
   logic [W-1:0]  s_x_inv;
   logic          u_in_ready, u_out_valid, u_div_zero, u_ovf;
   logic [W-1:0]  u_x_inv;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ops    = 0;

   always #5 clk = ~clk;

   recip_nr_pipe #(.W(W), .F(F), .ITERS(ITERS), .LUT_BITS(4), .SIGNED_MODE(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .x_in(x_in), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
      .x_inv(s_x_inv), .div_zero(s_div_zero), .ovf(s_ovf)
   );

   recip_nr_pipe #(.W(W), .F(F), .ITERS(ITERS), .LUT_BITS(4), .SIGNED_MODE(0)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
      .x_in(x_in), .flush(flush), .out_valid(u_out_valid), .out_ready(out_ready),
      .x_inv(u_x_inv), .div_zero(u_div_zero), .ovf(u_ovf)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input longint obs, input longint exp,
                            input longint tol);
      longint d;
      n_checks++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                  tag, obs, obs, exp, exp, tol);
      end
   endtask

   // Ideal result floor(2^(2F)/|x|), clamped to the representable magnitude.
   // The tolerance is 2 LSB while |x| >= 0.5; below that the normalised-domain
   // error is magnified by the denormalising left shift, so it scales with it.
   function automatic void model(input logic [W-1:0] x, input bit sgn,
                                 output longint ev, output longint tol,
                                 output bit dz, output bit ov, output bit ov_known);
      longint mag, y, maxv, sc;
      maxv = sgn ? 64'h7FFF_FFFF : 64'hFFFF_FFFF;
      if (sgn && x[W-1]) mag = (longint'(1) << W) - longint'(x);
      else               mag = longint'(x);
      if (mag == 0) begin
         ev = maxv; tol = 0; dz = 1'b1; ov = 1'b0; ov_known = 1'b1;
         return;
      end
      y  = (longint'(1) << (2 * F)) / mag;
      sc = 1;
      while (mag * sc < (longint'(1) << (F - 1))) sc = sc * 2;
      tol      = 2 * sc;
      dz       = 1'b0;
      ov       = (y > maxv);
      ov_known = (y > maxv + tol) || (y + tol < maxv);
      if (y > maxv) y = maxv;
      ev = (sgn && x[W-1]) ? -y : y;
   endfunction

   task automatic accept(input logic [W-1:0] x, input bit fl);
      int waitc;
      waitc = 0;
      while (!(s_in_ready && u_in_ready) && waitc < 40) begin
         @(posedge clk); #1; waitc++;
      end
      if (waitc >= 40) check_val("idle_wait", longint'(s_in_ready & u_in_ready), 1, 0);
      in_valid = 1'b1;
      x_in     = x;
      flush    = fl;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      x_in     = $urandom;
   endtask

   task automatic run_op(input logic [W-1:0] x, input int hold, input bit idle_flush,
                         output logic [W-1:0] s_got, output logic s_dz_got,
                         output logic s_ov_got, output logic [W-1:0] u_got);
      int     edges;
      longint s_ev, s_tol, u_ev, u_tol;
      bit     s_dz, s_ov, s_ok, u_dz, u_ov, u_ok;
      model(x, 1'b1, s_ev, s_tol, s_dz, s_ov, s_ok);
      model(x, 1'b0, u_ev, u_tol, u_dz, u_ov, u_ok);
      accept(x, idle_flush);
      edges = 0;
      while (!(s_out_valid && u_out_valid) && edges < 40) begin
         @(posedge clk); #1; edges++;
      end
      // Zero completes on the accepting edge itself; others LAT edges later.
      check_val("latency", edges, (x == '0) ? 0 : LAT, 0);
      s_got    = s_x_inv;
      s_dz_got = s_div_zero;
      s_ov_got = s_ovf;
      u_got    = u_x_inv;
      if (edges >= 40) begin
         rst_n = 1'b0; #2; rst_n = 1'b1;
         n_ops++;
         return;
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) begin
            @(posedge clk); #1;
         end
         check_val("s_inv", longint'($signed(s_x_inv)), s_ev, s_tol);
         check_val("s_dz", longint'(s_div_zero), longint'(s_dz), 0);
         if (s_ok) check_val("s_ovf", longint'(s_ovf), longint'(s_ov), 0);
         check_val("u_inv", longint'(u_x_inv), u_ev, u_tol);
         check_val("u_dz", longint'(u_div_zero), longint'(u_dz), 0);
         if (u_ok) check_val("u_ovf", longint'(u_ovf), longint'(u_ov), 0);
         check_val("out_rdy", longint'(s_in_ready | u_in_ready), 0, 0);
         check_val("out_vld", longint'(s_out_valid & u_out_valid), 1, 0);
         // An operand offered while a result is pending must be ignored.
         in_valid = 1'b1;
         x_in     = $urandom;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val("rel_rdy", longint'(s_in_ready & u_in_ready), 1, 0);
      check_val("rel_vld", longint'(s_out_valid | u_out_valid), 0, 0);
      $display("op %0d x=%08h lat=%0d s_inv=%08h s_dz=%0b s_ovf=%0b u_inv=%08h u_dz=%0b u_ovf=%0b",
               n_ops, x, edges, s_got, s_dz_got, s_ov_got, u_got, u_div_zero, u_ovf);
      n_ops++;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_rdy"}, longint'(s_in_ready & u_in_ready), 1, 0);
      check_val({tag, "_vld"}, longint'(s_out_valid | u_out_valid), 0, 0);
      check_val({tag, "_s_inv"}, longint'(s_x_inv), 0, 0);
      check_val({tag, "_u_inv"}, longint'(u_x_inv), 0, 0);
      check_val({tag, "_flags"}, longint'({s_div_zero, s_ovf, u_div_zero, u_ovf}), 0, 0);
   endtask

   initial begin
      logic [W-1:0] sv, uv, xr;
      logic         sd, so;
      int           seen;

      rst_n = 1'b0; in_valid = 1'b0; x_in = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2.0 -> 0.5
      run_op(32'h0002_0000, 0, 1'b0, sv, sd, so, uv);
      check_val("t1_inv", longint'($signed(sv)), 32'h0000_8000, 2);
      check_val("t1_ovf", longint'(so), 0, 0);

      // divide by zero
      run_op(32'h0000_0000, 0, 1'b0, sv, sd, so, uv);
      check_val("t2_inv", longint'(sv), 32'h7FFF_FFFF, 0);
      check_val("t2_dz", longint'(sd), 1, 0);

      // -4.0 -> -0.25
      run_op(32'hFFFC_0000, 0, 1'b0, sv, sd, so, uv);
      check_val("t3_inv", longint'($signed(sv)), -16384, 2);

      // smallest positive operand saturates
      run_op(32'h0000_0001, 0, 1'b0, sv, sd, so, uv);
      check_val("t3_sat", longint'(sv), 32'h7FFF_FFFF, 0);
      check_val("t3_ovf", longint'(so), 1, 0);

      // five cycles of back-pressure, released on the sixth
      run_op(32'h0005_0000, 5, 1'b0, sv, sd, so, uv);

      // flush while idle must not block a simultaneous accept
      run_op(32'h0003_0000, 1, 1'b1, sv, sd, so, uv);

      // flush during the second refinement step (iteration index 1, S_ITB)
      accept(32'h0007_0000, 1'b0);
      repeat (5) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check_val("flush_rdy", longint'(s_in_ready & u_in_ready), 1, 0);
      check_val("flush_vld", longint'(s_out_valid | u_out_valid), 0, 0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (s_out_valid || u_out_valid) seen++;
      end
      check_val("flush_quiet", seen, 0, 0);

      // asynchronous reset while denormalising
      accept(32'h0003_0000, 1'b0);
      repeat (8) @(posedge clk);
      #2; rst_n = 1'b0;
      #1; check_idle_outputs("async_rst");
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // most negative signed operand, and 32768.0 unsigned
      run_op(32'h8000_0000, 0, 1'b0, sv, sd, so, uv);
      check_val("t6_s_inv", longint'($signed(sv)), -2, 2);
      check_val("t6_u_inv", longint'(uv), 2, 1);

      for (int i = 0; i < N_RND; i++) begin
         xr = $urandom;
         case ($urandom_range(0, 3))
            0: xr = xr >> $urandom_range(0, 31);
            1: xr = 32'($urandom_range(0, 64));
            default: ;
         endcase
         run_op(xr, $urandom_range(0, 2), 1'b0, sv, sd, so, uv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
